// File: rtl/mu2f_pkg.sv
// Shared widths, stream FSM state and pointer search helpers for the MU track scheduler.
// Pure declarations: no latency, no backpressure.
package mu2f_pkg;

    localparam int NUM_TRACKS = 5;
    localparam int BURST_W    = 8;
    localparam int PTR_W      = $clog2(NUM_TRACKS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stream_state_t;

    function automatic logic [PTR_W-1:0] lowest_set_bit(input logic [NUM_TRACKS-1:0] mask);
        logic [PTR_W-1:0] res;
        res = '0;
        for (int i = NUM_TRACKS - 1; i >= 0; i--) begin
            if (mask[i]) res = PTR_W'(i);
        end
        return res;
    endfunction

    // Cyclic search strictly above cur; a mask holding only cur returns cur itself.
    function automatic logic [PTR_W-1:0] next_set_bit(input logic [NUM_TRACKS-1:0] mask,
                                                     input logic [PTR_W-1:0]      cur);
        logic [PTR_W-1:0] res;
        logic [PTR_W-1:0] idx;
        logic             found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_TRACKS; i++) begin
            idx = PTR_W'((int'(cur) + i) % NUM_TRACKS);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mu2f_stream_rotator.sv
// One stream's IDLE/RUN FSM, track pointer and burst counter; ptr/cnt update 1 cycle after the event.
// Observes handshakes only and never backpressures; clk_en=0 freezes all state.
module mu2f_stream_rotator
    import mu2f_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  tile_en,
    input  logic [NUM_TRACKS-1:0] eff_mask,
    input  logic [BURST_W-1:0]    burst_len,
    input  logic                  reload,
    input  logic                  fire,
    output logic                  running,
    output logic [PTR_W-1:0]      ptr,
    output logic                  burst_done
);

    stream_state_t      state;
    logic [BURST_W-1:0] cnt;
    logic [BURST_W-1:0] last_cnt;
    logic               mask_any;
    logic               ptr_owned;

    assign last_cnt  = (burst_len == '0) ? '0 : burst_len - BURST_W'(1);
    assign mask_any  = |eff_mask;
    assign ptr_owned = eff_mask[ptr];
    assign running   = (state == RUN);

    // A fire only completes a burst when no higher-priority RUN action takes the cycle.
    assign burst_done = running & tile_en & mask_any & ~reload & ptr_owned & fire
                        & (cnt == last_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (tile_en && mask_any) begin
                        state <= RUN;
                        ptr   <= lowest_set_bit(eff_mask);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!tile_en || !mask_any) begin
                        state <= IDLE;
                        ptr   <= '0;
                        cnt   <= '0;
                    end else if (reload) begin
                        ptr <= lowest_set_bit(eff_mask);
                        cnt <= '0;
                    end else if (!ptr_owned) begin
                        ptr <= next_set_bit(eff_mask, ptr);
                        cnt <= '0;
                    end else if (fire) begin
                        if (cnt == last_cnt) begin
                            cnt <= '0;
                            ptr <= next_set_bit(eff_mask, ptr);
                        end else begin
                            cnt <= cnt + BURST_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mu2f_track_scheduler.sv
// Rotates the two MU output streams across their owned fabric tracks in fixed-length bursts.
// Track controls follow registered state (1 cycle); handshakes are observed only, never stalled.
module mu2f_track_scheduler
    import mu2f_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  tile_en,
    input  logic [NUM_TRACKS-1:0] cfg_track_mask_0,
    input  logic [NUM_TRACKS-1:0] cfg_track_mask_1,
    input  logic [BURST_W-1:0]    cfg_burst_len_0,
    input  logic [BURST_W-1:0]    cfg_burst_len_1,
    input  logic                  cfg_reload,
    input  logic                  mu2io_16_0_valid,
    input  logic                  mu2io_16_0_ready,
    input  logic                  mu2io_16_1_valid,
    input  logic                  mu2io_16_1_ready,
    output logic                  track_select_T0,
    output logic                  track_select_T1,
    output logic                  track_select_T2,
    output logic                  track_select_T3,
    output logic                  track_select_T4,
    output logic                  track_active_T0,
    output logic                  track_active_T1,
    output logic                  track_active_T2,
    output logic                  track_active_T3,
    output logic                  track_active_T4,
    output logic                  burst_done_0,
    output logic                  burst_done_1,
    output logic                  cfg_err
);

    logic [NUM_TRACKS-1:0] eff_mask_0;
    logic [NUM_TRACKS-1:0] eff_mask_1;
    logic                  fire_0;
    logic                  fire_1;
    logic                  run_0;
    logic                  run_1;
    logic [PTR_W-1:0]      ptr_0;
    logic [PTR_W-1:0]      ptr_1;
    logic [NUM_TRACKS-1:0] active;
    logic [NUM_TRACKS-1:0] select;

    // Stream 0 owns any track both streams claim, so the effective masks are disjoint.
    assign eff_mask_0 = cfg_track_mask_0;
    assign eff_mask_1 = cfg_track_mask_1 & ~cfg_track_mask_0;

    assign fire_0 = mu2io_16_0_valid & mu2io_16_0_ready & clk_en & tile_en;
    assign fire_1 = mu2io_16_1_valid & mu2io_16_1_ready & clk_en & tile_en;

    mu2f_stream_rotator u_rot_0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .tile_en    (tile_en),
        .eff_mask   (eff_mask_0),
        .burst_len  (cfg_burst_len_0),
        .reload     (cfg_reload),
        .fire       (fire_0),
        .running    (run_0),
        .ptr        (ptr_0),
        .burst_done (burst_done_0)
    );

    mu2f_stream_rotator u_rot_1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .tile_en    (tile_en),
        .eff_mask   (eff_mask_1),
        .burst_len  (cfg_burst_len_1),
        .reload     (cfg_reload),
        .fire       (fire_1),
        .running    (run_1),
        .ptr        (ptr_1),
        .burst_done (burst_done_1)
    );

    always_comb begin
        active = '0;
        select = '0;
        for (int k = 0; k < NUM_TRACKS; k++) begin
            if (run_0 && (ptr_0 == PTR_W'(k))) active[k] = 1'b1;
            if (run_1 && (ptr_1 == PTR_W'(k))) begin
                active[k] = 1'b1;
                select[k] = 1'b1;
            end
        end
    end

    assign track_active_T0 = active[0];
    assign track_active_T1 = active[1];
    assign track_active_T2 = active[2];
    assign track_active_T3 = active[3];
    assign track_active_T4 = active[4];
    assign track_select_T0 = select[0];
    assign track_select_T1 = select[1];
    assign track_select_T2 = select[2];
    assign track_select_T3 = select[3];
    assign track_select_T4 = select[4];

    // Stream 0's effective mask equals its raw mask, so only stream 1 can be starved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else if (clk_en) begin
            cfg_err <= (|cfg_track_mask_1) & ~(|eff_mask_1);
        end
    end

endmodule

// File: tb/tb_mu2f_track_scheduler.sv
// Directed bench for the MU track scheduler: rotation, overlap, stalls, reload and async reset.
module tb_mu2f_track_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic       tile_en;
    logic [4:0] mask0;
    logic [4:0] mask1;
    logic [7:0] len0;
    logic [7:0] len1;
    logic       reload;
    logic       v0, r0, v1, r1;
    logic       sel_t0, sel_t1, sel_t2, sel_t3, sel_t4;
    logic       act_t0, act_t1, act_t2, act_t3, act_t4;
    logic       bd0, bd1, err;
    logic [4:0] act;
    logic [4:0] sel;

    int checks = 0;
    int passes = 0;

    assign act = {act_t4, act_t3, act_t2, act_t1, act_t0};
    assign sel = {sel_t4, sel_t3, sel_t2, sel_t1, sel_t0};

    always #5 clk = ~clk;

    mu2f_track_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .tile_en          (tile_en),
        .cfg_track_mask_0 (mask0),
        .cfg_track_mask_1 (mask1),
        .cfg_burst_len_0  (len0),
        .cfg_burst_len_1  (len1),
        .cfg_reload       (reload),
        .mu2io_16_0_valid (v0),
        .mu2io_16_0_ready (r0),
        .mu2io_16_1_valid (v1),
        .mu2io_16_1_ready (r1),
        .track_select_T0  (sel_t0),
        .track_select_T1  (sel_t1),
        .track_select_T2  (sel_t2),
        .track_select_T3  (sel_t3),
        .track_select_T4  (sel_t4),
        .track_active_T0  (act_t0),
        .track_active_T1  (act_t1),
        .track_active_T2  (act_t2),
        .track_active_T3  (act_t3),
        .track_active_T4  (act_t4),
        .burst_done_0     (bd0),
        .burst_done_1     (bd1),
        .cfg_err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [4:0] rot_act [7] = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00100, 5'b00100, 5'b00001};
    logic       rot_bd  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; tile_en = 1'b0; reload = 1'b0;
        mask0 = '0; mask1 = '0; len0 = '0; len1 = '0;
        v0 = 1'b0; r0 = 1'b0; v1 = 1'b0; r1 = 1'b0;
        tick(); tick();
        chk("reset_act", 32'(act), 32'h0);
        chk("reset_sel", 32'(sel), 32'h0);
        chk("reset_bd0", 32'(bd0), 32'h0);
        chk("reset_bd1", 32'(bd1), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        tick();

        // Static mapping: single-bit masks, stream 1 with burst length 0 (treated as 1)
        mask0 = 5'b00001; mask1 = 5'b10000; len0 = 8'd1; len1 = 8'd0; tile_en = 1'b1;
        #1;
        chk("static_pre_act", 32'(act), 32'h0);
        tick();
        chk("static_act", 32'(act), 32'h11);
        chk("static_sel", 32'(sel), 32'h10);
        v0 = 1'b1; r0 = 1'b1; v1 = 1'b1; r1 = 1'b1;
        #1;
        chk("static_bd0", 32'(bd0), 32'h1);
        chk("static_bd1_len0", 32'(bd1), 32'h1);
        tick();
        chk("static_hold_act", 32'(act), 32'h11);
        chk("static_hold_sel", 32'(sel), 32'h10);
        v0 = 1'b0; r0 = 1'b0; v1 = 1'b0; r1 = 1'b0; tile_en = 1'b0;
        tick();
        chk("tile_off_act", 32'(act), 32'h0);
        chk("tile_off_sel", 32'(sel), 32'h0);

        // Rotation over T0..T2 with two-word bursts
        mask0 = 5'b00111; mask1 = 5'b00000; len0 = 8'd2; tile_en = 1'b1;
        tick();
        chk("rot_start_act", 32'(act), 32'h01);
        v0 = 1'b1; r0 = 1'b1;
        for (int w = 0; w < 7; w++) begin
            #1;
            chk($sformatf("rot_act_w%0d", w + 1), 32'(act), 32'(rot_act[w]));
            chk($sformatf("rot_bd0_w%0d", w + 1), 32'(bd0), 32'(rot_bd[w]));
            tick();
        end

        // Stalls: ptr=T0, cnt=1 must survive clk_en=0 and ready=0
        clk_en = 1'b0;
        #1;
        chk("stall_clken_bd0", 32'(bd0), 32'h0);
        tick(); tick();
        chk("stall_clken_act", 32'(act), 32'h01);
        clk_en = 1'b1; r0 = 1'b0;
        tick(); tick();
        chk("stall_rdy_act", 32'(act), 32'h01);
        r0 = 1'b1;
        #1;
        chk("stall_resume_bd0", 32'(bd0), 32'h1);
        tick();
        chk("stall_resume_act", 32'(act), 32'h02);

        // Reload colliding with the terminal fire at T1
        #1;
        chk("rel_first_bd0", 32'(bd0), 32'h0);
        tick();
        reload = 1'b1;
        #1;
        chk("rel_collide_bd0", 32'(bd0), 32'h0);
        tick();
        chk("rel_ptr_act", 32'(act), 32'h01);
        reload = 1'b0;
        #1;
        chk("rel_cnt_clear_bd0", 32'(bd0), 32'h0);
        tick();
        #1;
        chk("rel_second_bd0", 32'(bd0), 32'h1);
        tick();
        chk("rel_after_act", 32'(act), 32'h02);
        v0 = 1'b0; r0 = 1'b0;

        // Overlap: stream 1's only track is taken by stream 0
        mask0 = 5'b00011; mask1 = 5'b00010; reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("ovl_act", 32'(act), 32'h01);
        chk("ovl_sel", 32'(sel), 32'h00);
        chk("ovl_err", 32'(err), 32'h1);
        mask1 = 5'b01000;
        tick();
        chk("ovl_fix_act", 32'(act), 32'h09);
        chk("ovl_fix_sel", 32'(sel), 32'h08);
        chk("ovl_fix_err", 32'(err), 32'h0);

        // Mask change removes stream 0's current track
        mask0 = 5'b00100;
        tick();
        chk("mask_jump_act", 32'(act), 32'h0C);

        // Reset in the middle of a burst
        mask0 = 5'b00110;
        tick();
        v0 = 1'b1; r0 = 1'b1;
        tick();
        v0 = 1'b0; r0 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_act", 32'(act), 32'h0);
        chk("arst_sel", 32'(sel), 32'h0);
        tile_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tile_en = 1'b1;
        tick();
        chk("post_rst_act", 32'(act), 32'h0A);
        chk("post_rst_sel", 32'(sel), 32'h08);
        v0 = 1'b1; r0 = 1'b1;
        #1;
        chk("post_rst_bd0_w1", 32'(bd0), 32'h0);
        tick();
        #1;
        chk("post_rst_bd0_w2", 32'(bd0), 32'h1);
        tick();
        chk("post_rst_rot_act", 32'(act), 32'h0C);
        v0 = 1'b0; r0 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
